// File: rtl/pixel_frame_interfaces.sv
// Pixel front end: serial bit loader with whole-frame handoff, plus nearest-index
// down-sampler and up-sampler. All three run concurrently on one clock/reset.

module nearest_resampler #(
  parameter int DATA_WIDTH = 16,
  parameter int IN_COUNT   = 32,
  parameter int OUT_COUNT  = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            i_start,
  input  logic [DATA_WIDTH*IN_COUNT-1:0]  i_vec,
  output logic [DATA_WIDTH*OUT_COUNT-1:0] o_vec,
  output logic                            o_busy,
  output logic                            o_done
);
  localparam int IDX_W = (OUT_COUNT > 1) ? $clog2(OUT_COUNT) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(OUT_COUNT - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  state_t                          r_state;
  logic [IDX_W-1:0]                r_idx;
  logic [DATA_WIDTH*IN_COUNT-1:0]  r_snap;
  logic [DATA_WIDTH*OUT_COUNT-1:0] r_vec;
  logic                            r_busy;
  logic                            r_done;
  logic [DATA_WIDTH-1:0]           w_word;

  // Nearest source index, computed in 32-bit integer arithmetic before clamping.
  function automatic int src_index(input logic [IDX_W-1:0] j);
    int v;
    v = (int'(j) * IN_COUNT) / OUT_COUNT;
    return (v > IN_COUNT - 1) ? IN_COUNT - 1 : v;
  endfunction

  // Snapshot word feeding the output slot being written this cycle.
  always_comb begin
    w_word = r_snap[src_index(r_idx)*DATA_WIDTH +: DATA_WIDTH];
  end

  // Start/run/done sequencer; a start arriving in the DONE cycle begins a new run.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
      r_snap  <= '0;
      r_vec   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_done <= 1'b0;
          if (i_start) begin
            r_snap  <= i_vec;
            r_idx   <= '0;
            r_busy  <= 1'b1;
            r_state <= ST_RUN;
          end
        end
        ST_RUN: begin
          r_done <= 1'b0;
          r_vec[r_idx*DATA_WIDTH +: DATA_WIDTH] <= w_word;
          if (r_idx == LAST_IDX) begin
            r_busy  <= 1'b0;
            r_state <= ST_DONE;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        ST_DONE: begin
          r_done <= 1'b1;
          if (i_start) begin
            r_snap  <= i_vec;
            r_idx   <= '0;
            r_busy  <= 1'b1;
            r_state <= ST_RUN;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign o_vec  = r_vec;
  assign o_busy = r_busy;
  assign o_done = r_done;
endmodule

module pixel_frame_interfaces #(
  parameter int DATA_WIDTH    = 16,
  parameter int PIXEL_COUNT   = 32,
  parameter int PIXEL_SCALE   = 8,
  parameter int FIFO_DEPTH    = 64,
  parameter int FIFO_ADDR_W   = 6,
  parameter int SAMPLE_COUNT  = 8,
  parameter int EXP_IN_COUNT  = 8,
  parameter int EXP_OUT_COUNT = 16
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                pixel_bit,
  input  logic                                pixel_bit_valid,
  output logic                                pixel_bit_ready,
  input  logic                                frame_consume,
  output logic                                frame_valid,
  output logic [DATA_WIDTH*PIXEL_COUNT-1:0]   frame_flat,
  input  logic                                sampler_start,
  output logic                                sampler_busy,
  output logic                                sampler_done,
  output logic [DATA_WIDTH*SAMPLE_COUNT-1:0]  sampled_flat,
  input  logic                                exp_start,
  input  logic [DATA_WIDTH*EXP_IN_COUNT-1:0]  exp_vector_in,
  output logic [DATA_WIDTH*EXP_OUT_COUNT-1:0] exp_vector_out,
  output logic                                exp_busy,
  output logic                                exp_done
);
  localparam int CNT_W = FIFO_ADDR_W + 1;
  localparam int PIX_W = (PIXEL_COUNT > 1) ? $clog2(PIXEL_COUNT) : 1;
  localparam logic [CNT_W-1:0]      FIFO_FULL = CNT_W'(FIFO_DEPTH);
  localparam logic [PIX_W-1:0]      PIX_LAST  = PIX_W'(PIXEL_COUNT - 1);
  localparam logic [DATA_WIDTH-1:0] ONE_WORD  = DATA_WIDTH'(32'd1) << PIXEL_SCALE;

  logic [FIFO_DEPTH-1:0]             r_fifo_mem;
  logic [FIFO_ADDR_W-1:0]            r_wr_ptr;
  logic [FIFO_ADDR_W-1:0]            r_rd_ptr;
  logic [CNT_W-1:0]                  r_fifo_cnt;
  logic                              r_ready;
  logic [DATA_WIDTH*PIXEL_COUNT-1:0] r_asm_buf;
  logic [PIX_W-1:0]                  r_asm_idx;
  logic                              r_asm_full;
  logic [DATA_WIDTH*PIXEL_COUNT-1:0] r_frame_flat;
  logic                              r_frame_valid;

  logic                  w_push;
  logic                  w_pop;
  logic                  w_handoff;
  logic [CNT_W-1:0]      w_cnt_next;
  logic [DATA_WIDTH-1:0] w_pix_word;

  // Handshake decode; a complete buffer blocks further pops until it is handed off.
  always_comb begin
    w_push     = pixel_bit_valid && r_ready;
    w_pop      = (r_fifo_cnt != '0) && !r_asm_full;
    w_handoff  = r_asm_full && (!r_frame_valid || frame_consume);
    w_pix_word = r_fifo_mem[r_rd_ptr] ? ONE_WORD : '0;
    case ({w_push, w_pop})
      2'b10:   w_cnt_next = r_fifo_cnt + 1'b1;
      2'b01:   w_cnt_next = r_fifo_cnt - 1'b1;
      default: w_cnt_next = r_fifo_cnt;
    endcase
  end

  // Bit FIFO; ready is registered from the next occupancy so it is 0 while in reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fifo_mem <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_fifo_cnt <= '0;
      r_ready    <= 1'b0;
    end else begin
      if (w_push) begin
        r_fifo_mem[r_wr_ptr] <= pixel_bit;
        r_wr_ptr             <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      r_fifo_cnt <= w_cnt_next;
      r_ready    <= (w_cnt_next < FIFO_FULL);
    end
  end

  // Frame assembly in arrival order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_asm_buf  <= '0;
      r_asm_idx  <= '0;
      r_asm_full <= 1'b0;
    end else if (w_pop) begin
      r_asm_buf[r_asm_idx*DATA_WIDTH +: DATA_WIDTH] <= w_pix_word;
      if (r_asm_idx == PIX_LAST) begin
        r_asm_idx  <= '0;
        r_asm_full <= 1'b1;
      end else begin
        r_asm_idx <= r_asm_idx + 1'b1;
      end
    end else if (w_handoff) begin
      r_asm_full <= 1'b0;
    end
  end

  // Output frame register: whole-frame copy, or release on consume.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_frame_flat  <= '0;
      r_frame_valid <= 1'b0;
    end else if (w_handoff) begin
      r_frame_flat  <= r_asm_buf;
      r_frame_valid <= 1'b1;
    end else if (frame_consume) begin
      r_frame_valid <= 1'b0;
    end
  end

  nearest_resampler #(
    .DATA_WIDTH(DATA_WIDTH),
    .IN_COUNT  (PIXEL_COUNT),
    .OUT_COUNT (SAMPLE_COUNT)
  ) u_sampler (
    .clk    (clk),
    .rst    (rst),
    .i_start(sampler_start),
    .i_vec  (r_frame_flat),
    .o_vec  (sampled_flat),
    .o_busy (sampler_busy),
    .o_done (sampler_done)
  );

  nearest_resampler #(
    .DATA_WIDTH(DATA_WIDTH),
    .IN_COUNT  (EXP_IN_COUNT),
    .OUT_COUNT (EXP_OUT_COUNT)
  ) u_expander (
    .clk    (clk),
    .rst    (rst),
    .i_start(exp_start),
    .i_vec  (exp_vector_in),
    .o_vec  (exp_vector_out),
    .o_busy (exp_busy),
    .o_done (exp_done)
  );

  assign pixel_bit_ready = r_ready;
  assign frame_valid     = r_frame_valid;
  assign frame_flat      = r_frame_flat;
endmodule

// File: tb/tb_pixel_frame_interfaces.sv
// Bench for pixel_frame_interfaces: queue-based reference model checked every
// cycle, directed scenarios with literal expectations, then a randomised phase.

module tb_pixel_frame_interfaces;
  localparam int DW   = 16;
  localparam int PC   = 32;
  localparam int SC   = 8;
  localparam int EIN  = 8;
  localparam int EOUT = 16;
  localparam int FW   = DW * PC;
  localparam int SW   = DW * SC;
  localparam int EIW  = DW * EIN;
  localparam int EOW  = DW * EOUT;

  localparam logic [SW-1:0] SMP_LIT = {16'h0000, 16'h0000, 16'h0100, 16'h0000,
                                       16'h0000, 16'h0000, 16'h0000, 16'h0100};
  localparam logic [EIW-1:0] EXP_IN = {16'd256, 16'd256, 16'd192, 16'd128,
                                       16'd0, 16'd0, 16'd0, 16'd0};
  localparam logic [EOW-1:0] EXP_LIT = {16'd256, 16'd256, 16'd256, 16'd256,
                                        16'd192, 16'd192, 16'd128, 16'd128,
                                        16'd0, 16'd0, 16'd0, 16'd0,
                                        16'd0, 16'd0, 16'd0, 16'd0};

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           pixel_bit = 1'b0;
  logic           pixel_bit_valid = 1'b0;
  logic           frame_consume = 1'b0;
  logic           sampler_start = 1'b0;
  logic           exp_start = 1'b0;
  logic [EIW-1:0] exp_vector_in = '0;
  logic           pixel_bit_ready, frame_valid, sampler_busy, sampler_done, exp_busy, exp_done;
  logic [FW-1:0]  frame_flat;
  logic [SW-1:0]  sampled_flat;
  logic [EOW-1:0] exp_vector_out;

  int n_checks = 0;
  int n_err = 0;

  pixel_frame_interfaces dut (
    .clk(clk), .rst(rst),
    .pixel_bit(pixel_bit), .pixel_bit_valid(pixel_bit_valid), .pixel_bit_ready(pixel_bit_ready),
    .frame_consume(frame_consume), .frame_valid(frame_valid), .frame_flat(frame_flat),
    .sampler_start(sampler_start), .sampler_busy(sampler_busy), .sampler_done(sampler_done),
    .sampled_flat(sampled_flat),
    .exp_start(exp_start), .exp_vector_in(exp_vector_in), .exp_vector_out(exp_vector_out),
    .exp_busy(exp_busy), .exp_done(exp_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic bit pat(input int mode, input int idx);
    return (mode == 0) ? (idx % 5 == 0) : (idx % 3 == 0);
  endfunction

  function automatic logic [FW-1:0] frame_pat(input int mode);
    logic [FW-1:0] f;
    f = '0;
    for (int i = 0; i < PC; i++) f[i*DW +: DW] = pat(mode, i) ? 16'h0100 : 16'h0000;
    return f;
  endfunction

  function automatic logic [EOW-1:0] resample(input logic [FW-1:0] src, input int in_n, input int out_n);
    logic [EOW-1:0] r;
    int k;
    r = '0;
    for (int j = 0; j < out_n; j++) begin
      k = (j * in_n) / out_n;
      if (k > in_n - 1) k = in_n - 1;
      r[j*DW +: DW] = src[k*DW +: DW];
    end
    return r;
  endfunction

  // Reference model state
  bit             m_fifo[$];
  logic [FW-1:0]  m_buf = '0;
  logic [FW-1:0]  m_frame = '0;
  int             m_k = 0;
  bit             m_complete = 1'b0;
  bit             m_fv = 1'b0;
  bit             m_ready = 1'b0;
  int             m_t[2] = '{-1, -1};
  bit             m_done[2] = '{1'b0, 1'b0};
  logic [EOW-1:0] m_pend[2] = '{'0, '0};
  logic [EOW-1:0] m_res[2] = '{'0, '0};

  task automatic model_step();
    bit push, pop, handoff, b, was_busy;
    bit start[2];
    int last[2];
    start[0] = sampler_start; start[1] = exp_start;
    last[0] = SC - 1;         last[1] = EOUT - 1;
    for (int u = 0; u < 2; u++) begin
      was_busy = (m_t[u] >= 0) && (m_t[u] <= last[u]);
      m_done[u] = (m_t[u] == last[u] + 1);
      if (m_done[u]) begin
        m_res[u] = m_pend[u];
        m_t[u] = -1;
      end else if (m_t[u] >= 0) begin
        m_t[u]++;
      end
      if (start[u] && !was_busy) begin
        m_pend[u] = (u == 0) ? resample(m_frame, PC, SC) : resample(FW'(exp_vector_in), EIN, EOUT);
        m_t[u] = 0;
      end
    end
    push    = pixel_bit_valid && m_ready;
    pop     = (m_fifo.size() > 0) && !m_complete;
    handoff = m_complete && (!m_fv || frame_consume);
    if (pop) begin
      b = m_fifo.pop_front();
      m_buf[m_k*DW +: DW] = b ? 16'h0100 : 16'h0000;
      m_k++;
      if (m_k == PC) begin
        m_k = 0;
        m_complete = 1'b1;
      end
    end
    if (push) m_fifo.push_back(pixel_bit);
    if (handoff) begin
      m_frame = m_buf;
      m_fv = 1'b1;
      m_complete = 1'b0;
    end else if (frame_consume) begin
      m_fv = 1'b0;
    end
    m_ready = (m_fifo.size() < 64);
  endtask

  initial begin : model
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_fifo.delete();
        m_buf = '0; m_frame = '0; m_k = 0;
        m_complete = 1'b0; m_fv = 1'b0; m_ready = 1'b0;
        for (int u = 0; u < 2; u++) begin
          m_t[u] = -1; m_done[u] = 1'b0; m_pend[u] = '0; m_res[u] = '0;
        end
      end else begin
        model_step();
      end
    end
  end

  initial begin : compare
    forever begin
      @(negedge clk);
      check1("ready", pixel_bit_ready, m_ready);
      check1("frame_valid", frame_valid, m_fv);
      check("frame_flat", frame_flat, m_frame);
      check1("sampler_busy", sampler_busy, (m_t[0] >= 0) && (m_t[0] < SC));
      check1("sampler_done", sampler_done, m_done[0]);
      if (m_t[0] < 0 || m_done[0]) check("sampled_flat", FW'(sampled_flat), FW'(m_res[0][SW-1:0]));
      check1("exp_busy", exp_busy, (m_t[1] >= 0) && (m_t[1] < EOUT));
      check1("exp_done", exp_done, m_done[1]);
      if (m_t[1] < 0 || m_done[1]) check("exp_vector_out", FW'(exp_vector_out), FW'(m_res[1]));
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic stream(input int n, input int mode, input bit gap, input int budget, output int accepted);
    int idx;
    bit on;
    idx = 0;
    for (int cyc = 0; cyc < budget && idx < n; cyc++) begin
      on = gap ? (cyc % 2 == 0) : 1'b1;
      pixel_bit_valid = on;
      pixel_bit = on ? pat(mode, idx) : 1'($urandom);
      if (on && pixel_bit_ready) idx++;
      tick();
    end
    pixel_bit_valid = 1'b0;
    accepted = idx;
  endtask

  task automatic wait_valid(input string name, input int budget);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      if (frame_valid) seen = 1'b1;
      else tick();
    end
    check1(name, seen, 1'b1);
  endtask

  task automatic run_resampler(input int u, output int lat, output int busy_cyc);
    if (u == 0) sampler_start = 1'b1;
    else exp_start = 1'b1;
    tick();
    sampler_start = 1'b0;
    exp_start = 1'b0;
    busy_cyc = (u == 0) ? int'(sampler_busy) : int'(exp_busy);
    lat = -1;
    for (int n = 1; n <= 40; n++) begin
      tick();
      if ((u == 0) ? sampler_busy : exp_busy) busy_cyc++;
      if ((u == 0) ? sampler_done : exp_done) begin
        lat = n;
        break;
      end
    end
  endtask

  initial begin : stimulus
    int acc, lat, bc, dones;
    bit seen;
    repeat (3) @(posedge clk);
    #1;
    check("reset_frame_flat", frame_flat, '0);
    check1("reset_frame_valid", frame_valid, 1'b0);
    check1("reset_sampler_busy", sampler_busy, 1'b0);
    rst = 1'b0;
    tick();
    check1("ready_after_reset", pixel_bit_ready, 1'b1);

    // Scenario 1: one frame, bit set on every fifth index
    stream(32, 0, 1'b0, 100, acc);
    check_int("s1_accepted", acc, 32);
    wait_valid("s1_frame_valid", 50);
    check("s1_frame_literal", frame_flat, frame_pat(0));
    check("s1_model_literal", m_frame, frame_pat(0));

    // Scenario 2: down-sample the held frame
    run_resampler(0, lat, bc);
    check_int("s2_latency", lat, 9);
    check_int("s2_busy_cycles", bc, 8);
    check("s2_sampled_literal", FW'(sampled_flat), FW'(SMP_LIT));
    check("s2_model_literal", FW'(m_res[0][SW-1:0]), FW'(SMP_LIT));

    // Scenario 3: up-sample a fixed vector
    exp_vector_in = EXP_IN;
    run_resampler(1, lat, bc);
    check_int("s3_latency", lat, 17);
    check_int("s3_busy_cycles", bc, 16);
    check("s3_expand_literal", FW'(exp_vector_out), FW'(EXP_LIT));

    // Scenario 4: back-pressure with frame 1 still held
    stream(96, 1, 1'b0, 200, acc);
    check_int("s4_accepted", acc, 96);
    tick();
    check1("s4_ready_low_when_full", pixel_bit_ready, 1'b0);
    check("s4_frame1_held", frame_flat, frame_pat(0));
    frame_consume = 1'b1;
    tick();
    frame_consume = 1'b0;
    check("s4_frame2_literal", frame_flat, frame_pat(1));
    check1("s4_valid_reasserted", frame_valid, 1'b1);
    seen = 1'b0;
    for (int i = 0; i < 4 && !seen; i++) begin
      tick();
      seen = pixel_bit_ready;
    end
    check1("s4_ready_recovers", seen, 1'b1);
    repeat (5) tick();

    // Scenario 5: start while busy is ignored, then async reset mid-run
    sampler_start = 1'b1;
    tick();
    sampler_start = 1'b0;
    repeat (2) tick();
    sampler_start = 1'b1;
    tick();
    sampler_start = 1'b0;
    dones = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (sampler_done) dones++;
    end
    check_int("s5_single_done", dones, 1);
    sampler_start = 1'b1;
    exp_start = 1'b1;
    tick();
    sampler_start = 1'b0;
    exp_start = 1'b0;
    repeat (3) tick();
    #2 rst = 1'b1;
    #1;
    check1("s5_rst_sampler_busy", sampler_busy, 1'b0);
    check1("s5_rst_exp_busy", exp_busy, 1'b0);
    check1("s5_rst_frame_valid", frame_valid, 1'b0);
    check("s5_rst_frame_flat", frame_flat, '0);
    check("s5_rst_sampled_flat", FW'(sampled_flat), '0);
    check("s5_rst_exp_out", FW'(exp_vector_out), '0);
    tick();
    rst = 1'b0;
    tick();

    // Scenario 6: gapped valid gives the same frame as scenario 1
    stream(32, 0, 1'b1, 200, acc);
    check_int("s6_accepted", acc, 32);
    wait_valid("s6_frame_valid", 50);
    check("s6_frame_literal", frame_flat, frame_pat(0));

    // Randomised phase
    for (int c = 0; c < 3000; c++) begin
      pixel_bit_valid = ($urandom_range(0, 9) < 7);
      pixel_bit       = 1'($urandom);
      frame_consume   = ($urandom_range(0, 15) == 0);
      sampler_start   = ($urandom_range(0, 19) == 0);
      exp_start       = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 7) == 0) exp_vector_in = {$urandom(), $urandom(), $urandom(), $urandom()};
      tick();
    end
    pixel_bit_valid = 1'b0;
    frame_consume = 1'b0;
    sampler_start = 1'b0;
    exp_start = 1'b0;
    repeat (30) tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
